// File: rtl/fade_pkg.sv
// Shared types and helpers for the RGB hue-wheel fade sequencer.
// Phase encoding follows the order in which the wheel is swept.
package fade_pkg;

   typedef enum logic [2:0] {
      PH_G_UP = 3'd0,
      PH_R_DN = 3'd1,
      PH_B_UP = 3'd2,
      PH_G_DN = 3'd3,
      PH_R_UP = 3'd4,
      PH_B_DN = 3'd5
   } phase_t;

   // Counter width that stays legal (>= 1 bit) even for a modulus of 1.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Ramp level n*inc clamped to full; dn at step 0 can reach PWM_INTERVAL.
   function automatic int unsigned ramp_sat(input int unsigned n,
                                            input int unsigned inc,
                                            input int unsigned full);
      int unsigned prod;
      prod = n * inc;
      return (prod > full) ? full : prod;
   endfunction

endpackage

// File: rtl/fade_ramp.sv
// Tick/step counter pair: step advances every INC_DEC_INTERVAL enabled cycles,
// step_wrap flags the enabled cycle on which step rolls over from its last value.
module fade_ramp
   import fade_pkg::*;
#(
   parameter int INC_DEC_INTERVAL = 10000,
   parameter int INC_DEC_MAX      = 200,
   parameter int SW               = cnt_width(INC_DEC_MAX)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          enable,
   output logic [SW-1:0] step,
   output logic          step_wrap
);

   localparam int TW = cnt_width(INC_DEC_INTERVAL);
   localparam logic [TW-1:0] TICK_LAST = TW'(INC_DEC_INTERVAL - 1);
   localparam logic [SW-1:0] STEP_LAST = SW'(INC_DEC_MAX - 1);

   logic [TW-1:0] tick_q;
   logic          tick_wrap;

   assign tick_wrap = enable && (tick_q == TICK_LAST);
   assign step_wrap = tick_wrap && (step == STEP_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_q <= '0;
         step   <= '0;
      end else if (enable) begin
         tick_q <= tick_wrap ? '0 : tick_q + 1'b1;
         if (tick_wrap)
            step <= (step == STEP_LAST) ? '0 : step + 1'b1;
      end
   end

endmodule

// File: rtl/rgb_fade_sequencer.sv
// Sweeps an RGB LED around the hue wheel: six phases, one channel ramping per phase.
// Duty outputs are a pure decode of the registered phase and step.
module rgb_fade_sequencer
   import fade_pkg::*;
#(
   parameter int PWM_INTERVAL     = 1200,
   parameter int INC_DEC_INTERVAL = 10000,
   parameter int INC_DEC_MAX      = 200,
   localparam int DW              = $clog2(PWM_INTERVAL)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          enable,
   output logic [DW-1:0] pwm_value_r,
   output logic [DW-1:0] pwm_value_g,
   output logic [DW-1:0] pwm_value_b,
   output logic [2:0]    phase,
   output logic          phase_done
);

   localparam int          SW          = cnt_width(INC_DEC_MAX);
   localparam int unsigned INC_DEC_VAL = PWM_INTERVAL / INC_DEC_MAX;
   localparam int unsigned MAX_U       = INC_DEC_MAX;
   localparam int unsigned FULL_U      = PWM_INTERVAL - 1;
   localparam logic [DW-1:0] FULL      = DW'(FULL_U);

   logic [SW-1:0] step;
   logic          step_wrap;
   phase_t        phase_q, phase_d;
   logic          done_q;
   logic [DW-1:0] up, dn;

   fade_ramp #(
      .INC_DEC_INTERVAL (INC_DEC_INTERVAL),
      .INC_DEC_MAX      (INC_DEC_MAX),
      .SW               (SW)
   ) u_ramp (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .step      (step),
      .step_wrap (step_wrap)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q <= PH_G_UP;
         done_q  <= 1'b0;
      end else begin
         phase_q <= phase_d;
         done_q  <= step_wrap;
      end
   end

   always_comb begin
      phase_d = phase_q;
      if (step_wrap) begin
         case (phase_q)
            PH_G_UP: phase_d = PH_R_DN;
            PH_R_DN: phase_d = PH_B_UP;
            PH_B_UP: phase_d = PH_G_DN;
            PH_G_DN: phase_d = PH_R_UP;
            PH_R_UP: phase_d = PH_B_DN;
            default: phase_d = PH_G_UP;
         endcase
      end
   end

   assign up = DW'(ramp_sat(32'(step), INC_DEC_VAL, FULL_U));
   assign dn = DW'(ramp_sat(MAX_U - 32'(step), INC_DEC_VAL, FULL_U));

   always_comb begin
      pwm_value_r = '0;
      pwm_value_g = '0;
      pwm_value_b = '0;
      case (phase_q)
         PH_G_UP: begin pwm_value_r = FULL; pwm_value_g = up;   end
         PH_R_DN: begin pwm_value_r = dn;   pwm_value_g = FULL; end
         PH_B_UP: begin pwm_value_g = FULL; pwm_value_b = up;   end
         PH_G_DN: begin pwm_value_g = dn;   pwm_value_b = FULL; end
         PH_R_UP: begin pwm_value_r = up;   pwm_value_b = FULL; end
         default: begin pwm_value_r = FULL; pwm_value_b = dn;   end
      endcase
   end

   assign phase      = phase_q;
   assign phase_done = done_q;

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Bench for rgb_fade_sequencer: a small-parameter instance checked every cycle
// against a cycle-count model, plus a default-width instance for saturation.
module tb_rgb_fade_sequencer;

   localparam int PI_A = 12,   II_A = 4, MX_A = 4,   DW_A = 4;
   localparam int PI_B = 1200, II_B = 2, MX_B = 200, DW_B = 11;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, en_a, en_b;
   logic [DW_A-1:0] r_a, g_a, b_a;
   logic [DW_B-1:0] r_b, g_b, b_b;
   logic [2:0]      phase_a, phase_b;
   logic            done_a, done_b;

   rgb_fade_sequencer #(.PWM_INTERVAL(PI_A), .INC_DEC_INTERVAL(II_A), .INC_DEC_MAX(MX_A)) dut_a (
      .clk(clk), .rst(rst), .enable(en_a),
      .pwm_value_r(r_a), .pwm_value_g(g_a), .pwm_value_b(b_a),
      .phase(phase_a), .phase_done(done_a)
   );

   rgb_fade_sequencer #(.PWM_INTERVAL(PI_B), .INC_DEC_INTERVAL(II_B), .INC_DEC_MAX(MX_B)) dut_b (
      .clk(clk), .rst(rst), .enable(en_b),
      .pwm_value_r(r_b), .pwm_value_g(g_b), .pwm_value_b(b_b),
      .phase(phase_b), .phase_done(done_b)
   );

   // ---------------- scoreboard ----------------
   int   errors = 0;
   int   checks = 0;
   int   n_a = 0;          // enabled cycles since reset seen by dut_a
   logic done_exp = 1'b0;
   int   pulses = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (n=%0d t=%0t)", tag, obs, exp, n_a, $time);
      end
   endtask

   // Expected channel level from the number of enabled cycles since reset.
   function automatic int exp_chan(input int n, input int ch);
      int steps, ph, st, inc, full, up, dn;
      int lvl [3];
      steps = n / II_A;
      ph    = (steps / MX_A) % 6;
      st    = steps % MX_A;
      inc   = PI_A / MX_A;
      full  = PI_A - 1;
      up    = st * inc;
      if (up > full) up = full;
      dn    = (MX_A - st) * inc;
      if (dn > full) dn = full;
      case (ph)
         0:       lvl = '{full, up,   0};
         1:       lvl = '{dn,   full, 0};
         2:       lvl = '{0,    full, up};
         3:       lvl = '{0,    dn,   full};
         4:       lvl = '{up,   0,    full};
         default: lvl = '{full, 0,    dn};
      endcase
      return lvl[ch];
   endfunction

   task automatic check_a(input string tag);
      check_val({tag, ".r"},     32'(r_a),     exp_chan(n_a, 0));
      check_val({tag, ".g"},     32'(g_a),     exp_chan(n_a, 1));
      check_val({tag, ".b"},     32'(b_a),     exp_chan(n_a, 2));
      check_val({tag, ".phase"}, 32'(phase_a), (n_a / II_A / MX_A) % 6);
      check_val({tag, ".done"},  32'(done_a),  32'(done_exp));
   endtask

   // ---------------- driver ----------------
   // Called at a falling edge; applies enable over one rising edge, then checks.
   task automatic cyc(input logic en);
      en_a = en;
      @(posedge clk);
      if (rst) begin
         n_a = 0;
         done_exp = 1'b0;
      end else if (en) begin
         n_a++;
         done_exp = (n_a % (II_A * MX_A)) == 0;
      end else begin
         done_exp = 1'b0;
      end
      @(negedge clk);
      if (done_a === 1'b1) pulses++;
      check_a("cyc");
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst  = 1'b1;
      en_a = 1'b0;
      en_b = 1'b0;
      repeat (2) @(negedge clk);
      check_a("por");
      rst = 1'b0;

      repeat (7) cyc(1'($urandom_range(0, 1)));

      // asynchronous reset seen before the next rising edge
      #2 rst = 1'b1;
      #1 n_a = 0; done_exp = 1'b0;
      check_a("async_rst");
      check_val("async_rst.r_full", 32'(r_a), 11);
      @(negedge clk);
      cyc(1'b1);
      rst = 1'b0;
      pulses = 0;

      // phase 0 ramp into phase 1
      repeat (16) cyc(1'b1);
      check_val("ph1.done", 32'(done_a), 1);
      check_val("ph1.phase", 32'(phase_a), 1);
      check_val("ph1.r", 32'(r_a), 11);
      check_val("ph1.g", 32'(g_a), 11);
      cyc(1'b1);
      check_val("ph1.done_once", 32'(done_a), 0);
      repeat (3) cyc(1'b1);
      check_val("ph1.r_step1", 32'(r_a), 9);

      // reach phase 2 step 1, then pause
      repeat (16) cyc(1'b1);
      check_val("ph2.b_step1", 32'(b_a), 3);
      repeat (10) cyc(1'b0);
      check_val("pause.b", 32'(b_a), 3);
      check_val("pause.phase", 32'(phase_a), 2);
      repeat (3) cyc(1'b1);
      check_val("pause.b_late", 32'(b_a), 3);
      cyc(1'b1);
      check_val("pause.b_next", 32'(b_a), 6);

      // enable dropped on the terminal tick suppresses the step
      repeat (3) cyc(1'b1);
      cyc(1'b0);
      check_val("term_drop.b", 32'(b_a), 6);
      cyc(1'b1);
      check_val("term_drop.b_next", 32'(b_a), 9);

      // complete the wheel
      for (int i = 0; i < 200 && n_a < 96; i++) cyc(1'b1);
      check_val("wheel.pulses", 32'(pulses), 6);
      check_val("wheel.phase", 32'(phase_a), 0);
      check_val("wheel.r", 32'(r_a), 11);
      check_val("wheel.g", 32'(g_a), 0);
      check_val("wheel.b", 32'(b_a), 0);

      // randomized enable pattern
      repeat (150) cyc(1'($urandom_range(0, 3) != 0));

      // reset in phase 3 step 2
      for (int i = 0; i < 200 && (n_a % 96) != 56; i++) cyc(1'b1);
      check_val("ph3s2.phase", 32'(phase_a), 3);
      check_val("ph3s2.g", 32'(g_a), 6);
      #2 rst = 1'b1;
      #1 n_a = 0; done_exp = 1'b0;
      check_a("midrun_rst");
      @(negedge clk);
      cyc(1'b0);
      rst = 1'b0;
      repeat (3) cyc(1'b1);
      check_val("restart.g_hold", 32'(g_a), 0);
      cyc(1'b1);
      check_val("restart.g_first", 32'(g_a), 3);

      // default widths: 1194 -> 1199 and dn saturation from 1200
      check_val("dflt.r_rst", 32'(r_b), 1199);
      check_val("dflt.g_rst", 32'(g_b), 0);
      en_b = 1'b1;
      repeat (199 * II_B) @(negedge clk);
      check_val("dflt.phase0", 32'(phase_b), 0);
      check_val("dflt.g_1194", 32'(g_b), 1194);
      check_val("dflt.r_full", 32'(r_b), 1199);
      repeat (II_B) @(negedge clk);
      check_val("dflt.phase1", 32'(phase_b), 1);
      check_val("dflt.done", 32'(done_b), 1);
      check_val("dflt.g_snap", 32'(g_b), 1199);
      check_val("dflt.r_sat", 32'(r_b), 1199);
      check_val("dflt.b", 32'(b_b), 0);
      repeat (II_B) @(negedge clk);
      check_val("dflt.r_step1", 32'(r_b), 1194);
      en_b = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
